// File: rtl/cpu_defs.sv
// Shared MIPS32 core definitions: opcodes, PC-source encodings and fetch FSM states.
// Imported by fetch, decode and control so all stages agree on the encodings.
package cpu_defs;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned JADDR_W = 26;
  localparam int unsigned SRC_W   = 2;

  localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;

  typedef enum logic [SRC_W-1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_JR     = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FETCH    = 2'b01,
    ST_WAIT_DEC = 2'b10,
    ST_HALTED   = 2'b11
  } fetch_state_e;

  // Instruction register payload: the fetched word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] w);
    return w[XLEN-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the decode-side
// valid/ready handshake and the redirect inputs supplied by decode.
interface instruction_fetch_if;
  import cpu_defs::*;

  logic                 imem_req;
  logic [XLEN-1:0]      imem_addr;
  logic                 imem_ack;
  logic [XLEN-1:0]      imem_rdata;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [XLEN-1:0]      instruction;
  logic [XLEN-1:0]      instr_pc;
  logic [XLEN-1:0]      pc_plus4;

  logic                 redirect;
  logic [SRC_W-1:0]     pc_src;
  logic [IMM_W-1:0]     imm16;
  logic [JADDR_W-1:0]   jaddr26;
  logic [XLEN-1:0]      reg_target;

  logic                 halted;
  logic [XLEN-1:0]      inst_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc, pc_plus4,
           halted, inst_count,
    input  imem_ack, imem_rdata, instr_ready, redirect, pc_src, imm16,
           jaddr26, reg_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc, pc_plus4,
           halted, inst_count,
    output imem_ack, imem_rdata, instr_ready, redirect, pc_src, imm16,
           jaddr26, reg_target
  );

endinterface

// File: rtl/next_pc_calc.sv
// Next-PC selection for the fetch stage: sequential, branch, jump or jump-register.
// Purely combinational so branch-prediction logic can reuse it.
module next_pc_calc
  import cpu_defs::*;
(
  input  logic [XLEN-1:0]    pc_plus4_i,
  input  logic               redirect_i,
  input  logic [SRC_W-1:0]   pc_src_i,
  input  logic [IMM_W-1:0]   imm16_i,
  input  logic [JADDR_W-1:0] jaddr26_i,
  input  logic [XLEN-1:0]    reg_target_i,
  output logic [XLEN-1:0]    next_pc_c_o
);

  localparam int unsigned BR_OFF_W = IMM_W + 2;
  localparam int unsigned SEG_W    = XLEN - JADDR_W - 2;

  logic [XLEN-1:0] br_off_c;
  logic [XLEN-1:0] br_target_c;
  logic [XLEN-1:0] j_target_c;
  logic [XLEN-1:0] jr_target_c;
  logic            unused_jr_lsb_c;

  // Low target bits of a register jump are dropped to keep fetches word aligned.
  assign unused_jr_lsb_c = ^reg_target_i[1:0];

  always_comb begin
    br_off_c    = {{(XLEN-BR_OFF_W){imm16_i[IMM_W-1]}}, imm16_i, 2'b00};
    br_target_c = pc_plus4_i + br_off_c;
    j_target_c  = {pc_plus4_i[XLEN-1 -: SEG_W], jaddr26_i, 2'b00};
    jr_target_c = {reg_target_i[XLEN-1:2], 2'b00};
    next_pc_c_o = pc_plus4_i;
    if (redirect_i) begin
      case (pc_src_e'(pc_src_i))
        PC_SEQ:    next_pc_c_o = pc_plus4_i;
        PC_BRANCH: next_pc_c_o = br_target_c;
        PC_JUMP:   next_pc_c_o = j_target_c;
        PC_JR:     next_pc_c_o = jr_target_c;
        default:   next_pc_c_o = pc_plus4_i;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS32 fetch stage: holds the PC, reads instruction memory with wait-state
// tolerance, and hands each word to decode over a valid/ready handshake.
module instruction_fetch
  import cpu_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic                 CLK,
  input logic                 RST,
  instruction_fetch_if.master bus
);

  localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [XLEN-1:0] count_q, count_d;
  fetch_word_t     ir_q, ir_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] next_pc_c;

  next_pc_calc u_next_pc (
    .pc_plus4_i   (pc_plus4_q),
    .redirect_i   (bus.redirect),
    .pc_src_i     (bus.pc_src),
    .imm16_i      (bus.imm16),
    .jaddr26_i    (bus.jaddr26),
    .reg_target_i (bus.reg_target),
    .next_pc_c_o  (next_pc_c)
  );

  // Next-state and registered-output logic; request/valid/halted are computed
  // one cycle ahead so they leave the block straight from flops.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    count_d    = count_q;
    ir_d       = ir_q;
    req_d      = req_q;
    valid_d    = valid_q;
    halted_d   = halted_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
      end

      ST_FETCH: begin
        if (req_q && bus.imem_ack) begin
          ir_d       = '{word: bus.imem_rdata, pc: pc_q};
          pc_plus4_d = pc_q + XLEN'(4);
          req_d      = 1'b0;
          valid_d    = 1'b1;
          state_d    = ST_WAIT_DEC;
        end
      end

      ST_WAIT_DEC: begin
        if (bus.instr_ready) begin
          count_d = count_q + XLEN'(1);
          pc_d    = next_pc_c;
          valid_d = 1'b0;
          if (opcode_of(ir_q.word) == OP_HALT) begin
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end else begin
            req_d   = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end

      ST_HALTED: begin
        req_d    = 1'b0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC_AL;
      pc_plus4_q <= XLEN'(4);
      count_q    <= '0;
      ir_q       <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instruction = ir_q.word;
  assign bus.instr_pc    = ir_q.pc;
  assign bus.pc_plus4    = pc_plus4_q;
  assign bus.halted      = halted_q;
  assign bus.inst_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: memory responder with wait states and
// stray acks, a decode driver, and a transaction-level model checked every cycle.
module tb_instruction_fetch;
  import cpu_defs::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic CLK = 1'b0;
  logic RST;

  instruction_fetch_if ifc ();

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] addr; int cyc; } req_rec_t;
  typedef struct {
    logic        rd;
    logic [1:0]  src;
    logic [15:0] imm;
    logic [25:0] j;
    logic [31:0] rt;
  } dec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_n    = 0;

  req_rec_t req_log[$];
  dec_t     script[$];

  // Stimulus knobs
  int          wait_min   = 0;
  int          wait_max   = 0;
  int          ready_mode = 0;
  bit          stray_en   = 1'b0;
  bit          force_ack  = 1'b0;
  bit          rand_redir = 1'b0;
  bit          halt_en    = 1'b0;
  logic [31:0] halt_addr  = 32'h0;

  // Model state
  logic [31:0] m_pc, m_ir_pc, m_count, cmp_w;
  bit          m_req, m_valid, m_halted, m_idle, prev_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    if (w[31:26] == OP_HALT) w[31:26] = 6'h00;
    if (halt_en && a == halt_addr) w[31:26] = OP_HALT;
    return w;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] ipc, input logic rd,
                                             input logic [1:0] src, input logic [15:0] imm,
                                             input logic [25:0] j, input logic [31:0] rt);
    logic [31:0] p4;
    p4 = ipc + 32'd4;
    if (!rd || src == 2'd0) return p4;
    if (src == 2'd1) return p4 + 32'($signed(imm)) * 32'd4;
    if (src == 2'd2) return (p4 & 32'hF000_0000) | (32'(j) << 2);
    return rt & ~32'd3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timed_out(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
  endtask

  // Compare process: check outputs against the model, then advance the model.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      m_pc = RST_PC; m_ir_pc = 32'h0; m_count = 32'h0;
      m_req = 1'b0; m_valid = 1'b0; m_halted = 1'b0; m_idle = 1'b1; prev_req = 1'b0;
    end else begin
      chk("imem_req", 32'(ifc.imem_req), 32'(m_req));
      chk("instr_valid", 32'(ifc.instr_valid), 32'(m_valid));
      chk("halted", 32'(ifc.halted), 32'(m_halted));
      chk("inst_count", ifc.inst_count, m_count);
      chk("imem_addr", ifc.imem_addr, m_pc);
      if (m_valid) begin
        chk("instruction", ifc.instruction, mem_word(m_ir_pc));
        chk("instr_pc", ifc.instr_pc, m_ir_pc);
        chk("pc_plus4", ifc.pc_plus4, m_ir_pc + 32'd4);
      end
      if (ifc.imem_req && !prev_req) req_log.push_back('{ifc.imem_addr, cyc});
      prev_req = ifc.imem_req;

      if (m_idle) begin
        m_idle = 1'b0;
        m_req  = 1'b1;
      end else if (m_req && ifc.imem_ack) begin
        m_ir_pc = m_pc;
        m_req   = 1'b0;
        m_valid = 1'b1;
      end else if (m_valid && ifc.instr_ready) begin
        hs_n++;
        m_count = m_count + 32'd1;
        m_pc    = model_next(m_ir_pc, ifc.redirect, ifc.pc_src, ifc.imm16,
                             ifc.jaddr26, ifc.reg_target);
        m_valid = 1'b0;
        cmp_w   = mem_word(m_ir_pc);
        if (cmp_w[31:26] == OP_HALT) m_halted = 1'b1;
        else                         m_req    = 1'b1;
      end
    end
  end

  // Instruction memory responder with programmable wait states and stray acks.
  initial begin
    bit busy;
    int wcnt;
    busy = 1'b0;
    wcnt = 0;
    ifc.imem_ack   = 1'b0;
    ifc.imem_rdata = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (ifc.imem_req && !RST) begin
        if (!busy) begin
          busy = 1'b1;
          wcnt = $urandom_range(wait_max, wait_min);
        end
        if (wcnt == 0) begin
          ifc.imem_ack   = 1'b1;
          ifc.imem_rdata = mem_word(ifc.imem_addr);
        end else begin
          ifc.imem_ack   = 1'b0;
          ifc.imem_rdata = $urandom;
          wcnt--;
        end
      end else begin
        busy           = 1'b0;
        ifc.imem_ack   = force_ack || (stray_en && $urandom_range(3, 0) == 0);
        ifc.imem_rdata = $urandom;
      end
    end
  end

  // Decode-side driver: ready policy plus scripted or random redirect fields.
  initial begin
    ifc.instr_ready = 1'b0;
    ifc.redirect    = 1'b0;
    ifc.pc_src      = 2'b00;
    ifc.imm16       = 16'h0;
    ifc.jaddr26     = 26'h0;
    ifc.reg_target  = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        0:       ifc.instr_ready = 1'b1;
        1:       ifc.instr_ready = ($urandom_range(9, 0) < 7);
        default: ifc.instr_ready = 1'b0;
      endcase
      if (script.size() > 0) begin
        ifc.redirect   = script[0].rd;
        ifc.pc_src     = script[0].src;
        ifc.imm16      = script[0].imm;
        ifc.jaddr26    = script[0].j;
        ifc.reg_target = script[0].rt;
      end else begin
        ifc.redirect   = rand_redir ? 1'($urandom_range(1, 0)) : 1'b0;
        ifc.pc_src     = 2'($urandom_range(3, 0));
        ifc.imm16      = 16'($urandom);
        ifc.jaddr26    = 26'($urandom);
        ifc.reg_target = $urandom;
      end
      @(negedge CLK);
      if (!RST && ifc.instr_valid && ifc.instr_ready && script.size() > 0)
        void'(script.pop_front());
    end
  end

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    req_log.delete();
    script.delete();
    @(negedge CLK);
    chk("rst_imem_req", 32'(ifc.imem_req), 32'd0);
    chk("rst_instr_valid", 32'(ifc.instr_valid), 32'd0);
    chk("rst_halted", 32'(ifc.halted), 32'd0);
    chk("rst_inst_count", ifc.inst_count, 32'd0);
    chk("rst_instruction", ifc.instruction, 32'd0);
    chk("rst_instr_pc", ifc.instr_pc, 32'd0);
    chk("rst_pc_plus4", ifc.pc_plus4, 32'd4);
    chk("rst_imem_addr", ifc.imem_addr, 32'h0000_0000);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int k = 0;
    while (req_log.size() < n && k < budget) begin
      @(posedge CLK);
      k++;
    end
    if (req_log.size() < n) timed_out(nm);
  endtask

  task automatic wait_hs(input int target, input int budget, input string nm);
    int k = 0;
    while (hs_n < target && k < budget) begin
      @(posedge CLK);
      k++;
    end
    if (hs_n < target) timed_out(nm);
  endtask

  task automatic push_dec(input logic rd, input logic [1:0] src, input logic [15:0] imm,
                          input logic [25:0] j, input logic [31:0] rt);
    script.push_back('{rd, src, imm, j, rt});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_redir [8];
    int base;
    int nreq;
    int k;

    RST = 1'b1;

    // Reset and sequential fetch with zero-wait memory
    wait_min = 0; wait_max = 0; ready_mode = 0; stray_en = 1'b0; rand_redir = 1'b0;
    do_reset();
    base = hs_n;
    wait_hs(base + 3, 200, "seq_three_handshakes");
    @(negedge CLK);
    chk("seq_inst_count", ifc.inst_count, 32'd3);
    if (req_log.size() >= 3) begin
      chk("seq_addr0", req_log[0].addr, 32'h0000_0000);
      chk("seq_addr1", req_log[1].addr, 32'h0000_0004);
      chk("seq_addr2", req_log[2].addr, 32'h0000_0008);
      chk("seq_gap", 32'(req_log[1].cyc - req_log[0].cyc), 32'd2);
      chk("seq_gap2", 32'(req_log[2].cyc - req_log[1].cyc), 32'd2);
    end else begin
      timed_out("seq_log");
    end

    // Memory wait states with stray acks outside FETCH
    wait_min = 3; wait_max = 3; stray_en = 1'b1; ready_mode = 1;
    base = hs_n;
    wait_hs(base + 20, 2000, "wait_state_run");

    // Backpressure: decode stalls for 5 cycles with a word pending
    ready_mode = 2; wait_min = 0; wait_max = 0;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!ifc.instr_valid && k < 50);
    if (!ifc.instr_valid) timed_out("bp_valid");
    nreq = 0;
    repeat (5) begin
      @(negedge CLK);
      if (ifc.imem_req) nreq++;
    end
    chk("bp_no_req", 32'(nreq), 32'd0);
    chk("bp_valid_held", 32'(ifc.instr_valid), 32'd1);
    ready_mode = 0;
    stray_en = 1'b0;

    // Redirects around 0x40, then the 32-bit wrap
    do_reset();
    push_dec(1'b1, 2'b11, 16'h0,    26'h0,       32'h0000_0040);
    push_dec(1'b1, 2'b01, 16'hFFFF, 26'h0,       32'h0);
    push_dec(1'b1, 2'b10, 16'h0,    26'h000_0100, 32'h0);
    push_dec(1'b1, 2'b11, 16'h0,    26'h0,       32'h0000_0040);
    push_dec(1'b1, 2'b11, 16'h0,    26'h0,       32'h0000_1003);
    push_dec(1'b1, 2'b11, 16'h0,    26'h0,       32'hFFFF_FFFC);
    push_dec(1'b0, 2'b00, 16'h0,    26'h0,       32'h0);
    exp_redir = '{32'h0000_0000, 32'h0000_0040, 32'h0000_0040, 32'h0000_0400,
                  32'h0000_0040, 32'h0000_1000, 32'hFFFF_FFFC, 32'h0000_0000};
    wait_log(8, 400, "redirect_log");
    if (req_log.size() >= 8) begin
      for (int i = 0; i < 8; i++)
        chk($sformatf("redir_addr%0d", i), req_log[i].addr, exp_redir[i]);
    end

    // HALT at 0x10 under random waits and backpressure
    do_reset();
    halt_en = 1'b1; halt_addr = 32'h0000_0010;
    wait_min = 0; wait_max = 2; ready_mode = 1; stray_en = 1'b1;
    k = 0;
    while (!ifc.halted && k < 500) begin
      @(posedge CLK);
      k++;
    end
    if (!ifc.halted) timed_out("halt_reached");
    nreq = 0;
    repeat (10) begin
      @(negedge CLK);
      if (ifc.imem_req) nreq++;
    end
    chk("halt_no_req", 32'(nreq), 32'd0);
    chk("halt_flag", 32'(ifc.halted), 32'd1);
    chk("halt_inst_count", ifc.inst_count, 32'd5);
    chk("halt_req_count", 32'(req_log.size()), 32'd5);
    chk("halt_next_pc", ifc.imem_addr, 32'h0000_0014);
    halt_en = 1'b0;

    // Reset while FETCH waits, with a late ack landing afterwards
    wait_min = 8; wait_max = 8; ready_mode = 0; stray_en = 1'b0;
    do_reset();
    k = 0;
    while (!ifc.imem_req && k < 20) begin
      @(posedge CLK);
      k++;
    end
    if (!ifc.imem_req) timed_out("midfetch_req");
    repeat (2) @(posedge CLK);
    force_ack = 1'b1;
    do_reset();
    @(negedge CLK);
    chk("late_ack_no_valid", 32'(ifc.instr_valid), 32'd0);
    @(posedge CLK);
    #1;
    force_ack = 1'b0;
    wait_min = 0; wait_max = 1;
    wait_log(1, 50, "post_reset_req");
    if (req_log.size() >= 1) chk("post_reset_addr", req_log[0].addr, 32'h0000_0000);
    base = hs_n;
    wait_hs(base + 2, 100, "post_reset_hs");

    // Long randomized run with random redirects
    do_reset();
    wait_min = 0; wait_max = 3; ready_mode = 1; stray_en = 1'b1; rand_redir = 1'b1;
    base = hs_n;
    wait_hs(base + 300, 10000, "random_run");

    repeat (3) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
